nto1_compact_fifo: RTL and testbench

//  N-lane to 1-lane compacting FIFO with valid/ready handshakes on both sides.

---
 rtl/nto1_compact_fifo_pkg.sv | 36 +++
 rtl/nto1_compact_fifo_entry_fifo.sv | 63 ++++++
 rtl/nto1_compact_fifo.sv | 109 ++++++++++
 tb/tb_nto1_compact_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nto1_compact_fifo_pkg.sv
`default_nettype none
//============================================================================
// Module   : nto1_pkg
// Brief    : Shared types and lane-mask helpers for the N-to-1 compacting FIFO.
// Revision : 1.0
//============================================================================
package nto1_pkg;

    localparam int C_N           = 4;
    localparam int C_DATA_WIDTH  = 8;
    localparam int C_MAX_N       = 32;
    localparam int C_MAX_IDX_W   = $clog2(C_MAX_N);

    typedef struct packed {
        logic [C_N-1:0]              mask;
        logic [C_N*C_DATA_WIDTH-1:0] data;
    } entry_t;

    // Helpers take a maximum-width mask so any lane count up to C_MAX_N can share them.
    function automatic logic [C_MAX_IDX_W-1:0] lowest_set(input logic [C_MAX_N-1:0] v);
        logic [C_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = C_MAX_N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = C_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [C_MAX_N-1:0] v);
        return (v != '0) && ((v & (v - C_MAX_N'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nto1_compact_fifo_entry_fifo.sv
`default_nettype none
//============================================================================
// Module   : nto1_entry_fifo
// Brief    : Wrap-bit pointer FIFO with first-word fall-through head and flush.
// Revision : 1.0
//============================================================================
module nto1_entry_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     full_o,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_PTR_W = C_IDX_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic               w_wr;
    logic               w_rd;

    assign full_o  = (r_wr_ptr[C_IDX_W-1:0] == r_rd_ptr[C_IDX_W-1:0]) &&
                     (r_wr_ptr[C_IDX_W] != r_rd_ptr[C_IDX_W]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);

    // Flush overrides both ports so a same-cycle handshake cannot survive the clear.
    assign w_wr = wr_en_i && !full_o && !flush_i;
    assign w_rd = rd_en_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[C_IDX_W-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr[C_IDX_W-1:0]];
    assign level_o   = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/nto1_compact_fifo.sv
`default_nettype none
//============================================================================
// Module   : nto1_compact_fifo
// Brief    : N-lane to 1-lane compacting FIFO; drains set lanes in ascending order.
// Revision : 1.0
//============================================================================
module nto1_compact_fifo
    import nto1_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N-1:0]              in_mask_i,
    input  logic [N*DATA_WIDTH-1:0]   in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic [$clog2(N)-1:0]      out_lane_o,
    output logic                      out_last_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                      afull_o
);

    localparam int                 C_LANE_W  = $clog2(N);
    localparam int                 C_LVL_W   = $clog2(DEPTH + 1);
    localparam int                 C_ENTRY_W = N * (DATA_WIDTH + 1);
    localparam logic [C_LVL_W-1:0] C_AF      = C_LVL_W'(AF_THRESH);
    localparam logic [N-1:0]       C_ONE     = N'(1);

    logic                    w_full;
    logic                    w_empty;
    logic [C_ENTRY_W-1:0]    w_head;
    logic [N-1:0]            w_head_mask;
    logic [N*DATA_WIDTH-1:0] w_head_data;
    logic [DATA_WIDTH-1:0]   w_lane [N];
    logic [N-1:0]            r_consumed;
    logic [N-1:0]            w_rem;
    logic [C_LANE_W-1:0]     w_sel;
    logic                    w_last;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_pop;

    // Zero-mask beats complete the handshake but never occupy an entry.
    assign in_ready_o = !w_full && !rst_i;
    assign w_in_fire  = in_valid_i && in_ready_o && (in_mask_i != '0);

    nto1_entry_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .wr_en_i   (w_in_fire),
        .wr_data_i ({in_mask_i, in_data_i}),
        .full_o    (w_full),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .empty_o   (w_empty),
        .level_o   (level_o)
    );

    assign w_head_mask = w_head[C_ENTRY_W-1 -: N];
    assign w_head_data = w_head[N*DATA_WIDTH-1:0];

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            assign w_lane[i] = w_head_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_rem  = w_head_mask & ~r_consumed;
    assign w_sel  = C_LANE_W'(lowest_set(C_MAX_N'(w_rem)));
    assign w_last = is_onehot(C_MAX_N'(w_rem));

    assign out_valid_o = !w_empty;
    assign out_data_o  = w_lane[w_sel];
    assign out_lane_o  = w_sel;
    assign out_last_o  = out_valid_o && w_last;
    assign afull_o     = (level_o >= C_AF);

    assign w_out_fire = out_valid_o && out_ready_i && !flush_i;
    assign w_pop      = w_out_fire && w_last;

    // Consumed lanes are tracked per head entry and cleared when the head retires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_consumed <= '0;
        end else if (flush_i) begin
            r_consumed <= '0;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_consumed <= '0;
            end else begin
                r_consumed <= r_consumed | (C_ONE << w_sel);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nto1_compact_fifo.sv
`default_nettype none
//============================================================================
// Module   : tb_nto1_compact_fifo
// Brief    : Randomised and directed scoreboard bench for nto1_compact_fifo.
// Revision : 1.0
//============================================================================
module tb_nto1_compact_fifo;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int LW    = $clog2(N);
    localparam int VW    = $clog2(DEPTH + 1);
    localparam int DWN   = N * DW;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [N-1:0]    in_mask_i = '0;
    logic [DWN-1:0]  in_data_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [DW-1:0]   out_data_o;
    logic [LW-1:0]   out_lane_o;
    logic            out_last_o;
    logic [VW-1:0]   level_o;
    logic            afull_o;

    nto1_compact_fifo #(
        .N          (N),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_mask_i   (in_mask_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_lane_o  (out_lane_o),
        .out_last_o  (out_last_o),
        .level_o     (level_o),
        .afull_o     (afull_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        logic          last;
    } word_t;

    // Reference: the stream of words still owed to the sink, in order.
    word_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    // Each stored beat contributes exactly one last-tagged word, so this is the level.
    function automatic int model_level();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i].last) c++;
        return c;
    endfunction

    always @(negedge clk_i) begin
        int  lvl;
        bit  had;
        lvl = model_level();
        if (rst_i) begin
            chk("rst_in_ready", int'(in_ready_o), 0);
            chk("rst_out_valid", int'(out_valid_o), 0);
            chk("rst_out_last", int'(out_last_o), 0);
            chk("rst_level", int'(level_o), 0);
            chk("rst_afull", int'(afull_o), 0);
            exp_q.delete();
        end else begin
            chk("level", int'(level_o), lvl);
            chk("afull", int'(afull_o), int'(lvl >= AF));
            chk("in_ready", int'(in_ready_o), int'(lvl < DEPTH));
            chk("out_valid", int'(out_valid_o), int'(exp_q.size() > 0));
            if (out_valid_o && exp_q.size() > 0) begin
                chk("out_data", int'(out_data_o), int'(exp_q[0].d));
                chk("out_lane", int'(out_lane_o), int'(exp_q[0].l));
                chk("out_last", int'(out_last_o), int'(exp_q[0].last));
            end
            if (flush_i) begin
                exp_q.delete();
            end else begin
                had = (exp_q.size() > 0);
                if (in_valid_i && in_ready_o) begin
                    for (int i = 0; i < N; i++) begin
                        if (in_mask_i[i]) begin
                            word_t w;
                            w.d    = in_data_i[i*DW +: DW];
                            w.l    = LW'(i);
                            w.last = ((in_mask_i >> (i + 1)) == '0);
                            exp_q.push_back(w);
                        end
                    end
                end
                if (out_valid_o && out_ready_i && had) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [N-1:0] m, input logic [DWN-1:0] d);
        int t = 0;
        in_valid_i = 1'b1;
        in_mask_i  = m;
        in_data_i  = d;
        while (!in_ready_o && t < 200) begin
            cyc();
            t++;
        end
        if (t >= 200) chk("beat_accept_timeout", 1, 0);
        cyc();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready_i = 1'b1;
        while (exp_q.size() > 0 && t < 500) begin
            cyc();
            t++;
        end
        if (t >= 500) chk("drain_timeout", 1, 0);
        cyc();
    endtask

    initial begin
        repeat (3) cyc();
        rst_i = 1'b0;
        cyc();

        // Sparse mask compaction
        out_ready_i = 1'b1;
        beat(4'b1011, {8'd44, 8'd33, 8'd22, 8'd11});
        drain();

        // Fill to full with no reads, hold a ninth beat, then free one slot
        out_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) beat(4'b0001, DWN'($urandom));
        in_valid_i = 1'b1;
        in_mask_i  = 4'b0001;
        in_data_i  = DWN'($urandom);
        repeat (3) cyc();
        chk("full_holds_in_ready", int'(in_ready_o), 0);
        out_ready_i = 1'b1;
        cyc();
        out_ready_i = 1'b0;
        chk("ready_after_pop", int'(in_ready_o), 1);
        cyc();
        in_valid_i = 1'b0;
        drain();

        // Zero-mask beat is swallowed
        out_ready_i = 1'b0;
        beat(4'b0000, DWN'($urandom));
        repeat (2) cyc();
        chk("zero_mask_level", int'(level_o), 0);

        // Back-pressure stability
        beat(4'b1111, DWN'($urandom));
        for (int i = 0; i < 10; i++) begin
            out_ready_i = ~i[0];
            cyc();
        end
        drain();

        // Pointer wrap with concurrent drain
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) beat(4'b1000, DWN'($urandom));
        drain();

        // Flush mid-drain, then a fresh beat
        beat(4'b0111, DWN'($urandom));
        cyc();
        cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("flush_level", int'(level_o), 0);
        chk("flush_out_valid", int'(out_valid_o), 0);
        beat(4'b0110, DWN'($urandom));
        drain();

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        beat(4'b0101, DWN'($urandom));
        beat(4'b1100, DWN'($urandom));
        cyc();
        rst_i = 1'b1;
        #2;
        chk("async_rst_out_valid", int'(out_valid_o), 0);
        cyc();
        rst_i = 1'b0;
        chk("post_rst_level", int'(level_o), 0);
        beat(4'b1010, DWN'($urandom));
        drain();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            in_valid_i  = ($urandom_range(0, 1) == 1);
            in_mask_i   = N'($urandom);
            in_data_i   = DWN'($urandom);
            out_ready_i = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 59) == 0);
            cyc();
        end
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
